// File: rtl/core_ctrl_if.sv
// core_ctrl_if: pipeline-control bundle between the datapath and core_ctrl.
//   Datapath -> controller: jump_flag_in, jump_addr_in, load_pending_in,
//     ex_rd_in, id_rs1_in, id_rs2_in, id_uses_rs1_in, id_uses_rs2_in, halt_req_in
//   Controller -> datapath: pc_we_out, pc_next_out, hold_pc_out, hold_if_id_out,
//     flush_if_id_out, flush_id_ex_out, halted_out, state_out
//   slave modport is the controller view, master modport is the datapath view.
interface core_ctrl_if;
  logic        jump_flag_in;
  logic [31:0] jump_addr_in;
  logic        load_pending_in;
  logic [4:0]  ex_rd_in;
  logic [4:0]  id_rs1_in;
  logic [4:0]  id_rs2_in;
  logic        id_uses_rs1_in;
  logic        id_uses_rs2_in;
  logic        halt_req_in;

  logic        pc_we_out;
  logic [31:0] pc_next_out;
  logic        hold_pc_out;
  logic        hold_if_id_out;
  logic        flush_if_id_out;
  logic        flush_id_ex_out;
  logic        halted_out;
  logic [1:0]  state_out;

  modport slave (
    input  jump_flag_in, jump_addr_in, load_pending_in, ex_rd_in,
           id_rs1_in, id_rs2_in, id_uses_rs1_in, id_uses_rs2_in, halt_req_in,
    output pc_we_out, pc_next_out, hold_pc_out, hold_if_id_out,
           flush_if_id_out, flush_id_ex_out, halted_out, state_out
  );

  modport master (
    output jump_flag_in, jump_addr_in, load_pending_in, ex_rd_in,
           id_rs1_in, id_rs2_in, id_uses_rs1_in, id_uses_rs2_in, halt_req_in,
    input  pc_we_out, pc_next_out, hold_pc_out, hold_if_id_out,
           flush_if_id_out, flush_id_ex_out, halted_out, state_out
  );
endinterface

// File: rtl/core_ctrl.sv
// core_ctrl: pipeline hazard/redirect/halt controller.
//   clk  : pipeline clock, rising edge
//   rst  : asynchronous reset, active low
//   ctrl : core_ctrl_if.slave bundle (jump, load-use hazard, halt inputs;
//          PC write/redirect, hold, flush, halted and state outputs)
// Only state, cnt and halt_pend are registered; every control output is a
// combinational function of state and inputs, forced to 0 while rst is low.
module core_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned STALL_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  core_ctrl_if.slave  ctrl
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] FLUSH_INIT = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] STALL_INIT = CNT_W'(STALL_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_halt_pend, w_halt_pend_nxt;

  logic w_hazard;
  logic w_halt_any;
  logic w_pc_we, w_hold, w_flush_if, w_flush_ex, w_halted;

  // Load-use hazard: EX load writes a register that ID is about to read.
  assign w_hazard = ctrl.load_pending_in && (ctrl.ex_rd_in != 5'd0) &&
                    ((ctrl.id_uses_rs1_in && (ctrl.id_rs1_in == ctrl.ex_rd_in)) ||
                     (ctrl.id_uses_rs2_in && (ctrl.id_rs2_in == ctrl.ex_rd_in)));

  // A halt requested on the last cycle of a sequence is honoured on exit too.
  assign w_halt_any = r_halt_pend || ctrl.halt_req_in;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_RUN;
      r_cnt       <= '0;
      r_halt_pend <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_halt_pend <= w_halt_pend_nxt;
    end
  end

  // Next-state and control outputs
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_halt_pend_nxt = r_halt_pend;
    w_pc_we         = 1'b0;
    w_hold          = 1'b0;
    w_flush_if      = 1'b0;
    w_flush_ex      = 1'b0;
    w_halted        = 1'b0;

    unique case (r_state)
      ST_RUN, ST_STALL: begin
        if (ctrl.jump_flag_in) begin
          w_pc_we    = 1'b1;
          w_flush_if = 1'b1;
          w_flush_ex = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            w_state_nxt     = ST_FLUSH;
            w_cnt_nxt       = FLUSH_INIT;
            w_halt_pend_nxt = (r_state == ST_STALL) ? w_halt_any : ctrl.halt_req_in;
          end else begin
            // Single-cycle redirect: the sequence ends here, so a halt applies now.
            w_state_nxt     = ((r_state == ST_STALL) ? w_halt_any : ctrl.halt_req_in)
                              ? ST_HALT : ST_RUN;
            w_cnt_nxt       = '0;
            w_halt_pend_nxt = 1'b0;
          end
        end else if (r_state == ST_STALL) begin
          w_hold     = 1'b1;
          w_flush_ex = 1'b1;
          if (r_cnt <= CNT_W'(1)) begin
            w_state_nxt     = w_halt_any ? ST_HALT : ST_RUN;
            w_cnt_nxt       = '0;
            w_halt_pend_nxt = 1'b0;
          end else begin
            w_cnt_nxt       = r_cnt - CNT_W'(1);
            w_halt_pend_nxt = w_halt_any;
          end
        end else if (w_hazard) begin
          w_hold     = 1'b1;
          w_flush_ex = 1'b1;
          if (STALL_CYCLES > 1) begin
            w_state_nxt     = ST_STALL;
            w_cnt_nxt       = STALL_INIT;
            w_halt_pend_nxt = ctrl.halt_req_in;
          end else begin
            w_state_nxt     = ctrl.halt_req_in ? ST_HALT : ST_RUN;
            w_cnt_nxt       = '0;
            w_halt_pend_nxt = 1'b0;
          end
        end else if (ctrl.halt_req_in) begin
          w_state_nxt = ST_HALT;
        end
      end

      ST_FLUSH: begin
        w_flush_if = 1'b1;
        w_flush_ex = 1'b1;
        if (r_cnt <= CNT_W'(1)) begin
          w_state_nxt     = w_halt_any ? ST_HALT : ST_RUN;
          w_cnt_nxt       = '0;
          w_halt_pend_nxt = 1'b0;
        end else begin
          w_cnt_nxt       = r_cnt - CNT_W'(1);
          w_halt_pend_nxt = w_halt_any;
        end
      end

      ST_HALT: begin
        w_hold          = 1'b1;
        w_flush_ex      = 1'b1;
        w_halted        = 1'b1;
        w_halt_pend_nxt = 1'b0;
        if (!ctrl.halt_req_in) begin
          w_state_nxt = ST_RUN;
        end
      end

      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase
  end

  // Outputs are gated by reset so they drop immediately on assertion.
  assign ctrl.pc_we_out       = rst && w_pc_we;
  assign ctrl.pc_next_out     = (rst && w_pc_we) ? ctrl.jump_addr_in : 32'd0;
  assign ctrl.hold_pc_out     = rst && w_hold;
  assign ctrl.hold_if_id_out  = rst && w_hold;
  assign ctrl.flush_if_id_out = rst && w_flush_if;
  assign ctrl.flush_id_ex_out = rst && w_flush_ex;
  assign ctrl.halted_out      = rst && w_halted;
  assign ctrl.state_out       = rst ? 2'(r_state) : 2'd0;

endmodule

// File: doc/core_ctrl.md
CORE_CTRL -- requirements
Module: core_ctrl

Interface
REQ-001 Parameter FLUSH_CYCLES, 2, total cycles flush asserted per taken jump; legal 1..15.
REQ-002 Parameter STALL_CYCLES, 2, total cycles hold asserted per load-use hazard; legal 1..15.
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  pipeline clock, rising edge.
REQ-005 rst  in  1  asynchronous reset, active low.
REQ-006 jump_flag_in  in  1  EX resolved a taken jump or branch.
REQ-007 jump_addr_in  in  32  jump target address.
REQ-008 load_pending_in  in  1  EX holds a load.
REQ-009 ex_rd_in  in  5  EX destination register.
REQ-010 id_rs1_in, id_rs2_in  in  5 each  ID source registers.
REQ-011 id_uses_rs1_in, id_uses_rs2_in  in  1 each  ID reads rs1/rs2.
REQ-012 halt_req_in  in  1  debug halt request, level.
REQ-013 pc_we_out  out  1  load PC with pc_next_out.
REQ-014 pc_next_out  out  32  redirect address.
REQ-015 hold_pc_out, hold_if_id_out  out  1 each  freeze PC / IF-ID register.
REQ-016 flush_if_id_out, flush_id_ex_out  out  1 each  insert bubble.
REQ-017 halted_out  out  1  core halted.
REQ-018 state_out  out  2  RUN=0, STALL=1, FLUSH=2, HALT=3.

Function
REQ-019 Registered state: FSM state, 4-bit counter cnt, halt_pend flag; all other outputs combinational from state and inputs.
REQ-020 hazard = load_pending_in & ex_rd_in!=0 & ((id_uses_rs1_in & id_rs1_in==ex_rd_in) | (id_uses_rs2_in & id_rs2_in==ex_rd_in)).
REQ-021 Priority in any state: jump > hazard > halt.
REQ-022 Jump (jump_flag_in=1, state RUN or STALL): same cycle pc_we_out=1, pc_next_out=jump_addr_in, flush_if_id_out=1, flush_id_ex_out=1; next state FLUSH with cnt=FLUSH_CYCLES-1 if FLUSH_CYCLES>1, else RUN.
REQ-023 pc_next_out = 0 whenever pc_we_out = 0.
REQ-024 FLUSH: flush_if_id_out=1, flush_id_ex_out=1; cnt decrements each cycle; when cnt==1, next state HALT if halt_pend else RUN; jump_flag_in ignored.
REQ-025 Hazard in RUN without jump: same cycle hold_pc_out=1, hold_if_id_out=1, flush_id_ex_out=1; next state STALL with cnt=STALL_CYCLES-1 if STALL_CYCLES>1, else RUN.
REQ-026 STALL: hold_pc_out=1, hold_if_id_out=1, flush_id_ex_out=1; cnt decrements; when cnt==1 next state HALT if halt_pend else RUN; hazard re-evaluated only in RUN.
REQ-027 halt_req_in=1 in RUN with no jump/hazard: next state HALT; in STALL/FLUSH: set halt_pend, honoured on exit.
REQ-028 HALT: hold_pc_out=1, hold_if_id_out=1, flush_id_ex_out=1, halted_out=1; jump_flag_in and hazard ignored; halt_req_in=0 -> RUN next cycle, halt_pend cleared.
REQ-029 RUN with no event: all control outputs 0.

Reset
REQ-030 rst=0 forces state RUN, cnt=0, halt_pend=0 immediately, independent of clk.
REQ-031 While rst=0 every output is 0, regardless of inputs.
REQ-032 Reset mid-FLUSH/STALL/HALT abandons the sequence; first cycle after release is RUN.

Verification
REQ-033 RUN, jump_flag_in=1, jump_addr_in=0x0000_0100 -> pc_we_out=1, pc_next_out=0x100, both flushes 1 that cycle; next cycle state_out=2, flushes 1; following cycle state_out=0, outputs 0.
REQ-034 load_pending_in=1, ex_rd_in=5, id_rs2_in=5, id_uses_rs2_in=1 -> hold_pc_out/hold_if_id_out/flush_id_ex_out=1 for 2 cycles (state 0 then 1), then RUN; same with ex_rd_in=0 -> no stall.
REQ-035 halt_req_in=1 asserted during FLUSH -> FLUSH completes, then state_out=3, halted_out=1 until halt_req_in=0, then RUN next cycle.
REQ-036 Same cycle jump_flag_in=1, hazard true, halt_req_in=1 -> jump taken, state FLUSH, halt_pend=1, HALT after FLUSH.
REQ-037 rst=0 asserted mid-STALL between clock edges -> outputs 0 immediately; after release state_out=0, no residual hold.
REQ-038 FLUSH_CYCLES=1, STALL_CYCLES=1 -> jump and hazard each assert outputs exactly one cycle, state_out stays 0.
